// File: rtl/legv8_alu_pkg.sv
// Shared LEGv8 ALU/divider definitions: operand width, divider FSM states and
// the most-negative signed constant.
package legv8_alu_pkg;

    localparam int DIV_W = 64;

    localparam logic [DIV_W-1:0] SIGNED_MIN = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/legv8_seq_divider_if.sv
// Request/response bundle between the execute stage (master) and the
// sequential divider (slave).
interface legv8_seq_divider_if
    import legv8_alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/legv8_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference when it does not borrow.
module legv8_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // The incoming remainder is always below twice the divisor, so the signed
    // WIDTH+1 bit difference cannot overflow and its MSB is the borrow.
    assign trial    = rem - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign next_rem = q_bit ? trial[WIDTH-1:0] : rem[WIDTH-1:0];

endmodule

// File: rtl/legv8_seq_divider.sv
// Multi-cycle radix-2 restoring divider for LEGv8 UDIV/SDIV, one bit per cycle.
// Optional build macro DIVIDER_EARLY_OUT_EN skips the iterations when the quotient is trivially 0.
module legv8_seq_divider
    import legv8_alu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input logic                 clk,
    input logic                 rst_n,
    legv8_seq_divider_if.slave  bus
);

    localparam int               CNT_W      = 7;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor_mag;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic             accept;
    logic             early_out;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;

    logic [WIDTH-1:0] step_rem;
    logic             step_q_bit;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    // Signed operands are reduced to magnitudes; MIN maps onto itself, which
    // is its correct unsigned magnitude.
    assign dividend_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign divisor_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    assign dividend_abs = dividend_neg ? -bus.dividend : bus.dividend;
    assign divisor_abs  = divisor_neg  ? -bus.divisor  : bus.divisor;

`ifdef DIVIDER_EARLY_OUT_EN
    assign early_out = (divisor_abs == '0) || (dividend_abs < divisor_abs);
`else
    assign early_out = 1'b0;
`endif

    legv8_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      ({rem, quo[WIDTH-1]}),
        .divisor  (divisor_mag),
        .next_rem (step_rem),
        .q_bit    (step_q_bit)
    );

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: assign a default before the case so no path leaves state_next
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = early_out ? FIX : CALC;
            end
            CALC: begin
                if (count == '0) state_next = FIX;
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (accept) state_next = early_out ? FIX : CALC;
                else        state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC) || (state == FIX);
        bus.done = (state == DONE);
    end

    // Working registers; an early-out preloads the remainder with the dividend
    // so FIX sees the same values the full iteration would have produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor_mag <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
        end else if (accept) begin
            count       <= LAST_COUNT;
            divisor_mag <= divisor_abs;
            neg_q       <= dividend_neg ^ divisor_neg;
            neg_r       <= dividend_neg;
            zero_div    <= (bus.divisor == '0);
            if (early_out) begin
                rem <= dividend_abs;
                quo <= '0;
            end else begin
                rem <= '0;
                quo <= dividend_abs;
            end
        end else if (state == CALC) begin
            rem   <= step_rem;
            quo   <= {quo[WIDTH-2:0], step_q_bit};
            count <= count - 1'b1;
        end
    end

    // With a zero divisor the iteration leaves |dividend| in rem, so only the
    // quotient needs forcing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else if (state == FIX) begin
            quotient_q    <= zero_div ? '0 : (neg_q ? -quo : quo);
            remainder_q   <= neg_r ? -rem : rem;
            div_by_zero_q <= zero_div;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule
